// File: rtl/calc_sequencer_if.sv
// ALU handshake between the calculator sequencer (master) and the ALU (slave).
// Latency: start is a one-cycle strobe answered later by a one-cycle done strobe; no backpressure.
interface calc_sequencer_if;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_op;
  logic       alu_start;
  logic [7:0] alu_result;
  logic       alu_done;
  logic       alu_err;

  modport master (
    output alu_a, alu_b, alu_op, alu_start,
    input  alu_result, alu_done, alu_err
  );

  modport slave (
    input  alu_a, alu_b, alu_op, alu_start,
    output alu_result, alu_done, alu_err
  );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator control FSM: debounced buttons, operand/op capture, ALU start/done with timeout.
// Latency: 2-cycle synchronisers + DEBOUNCE_CYCLES per button; no backpressure, ALU must answer with done.
module calc_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20,
  parameter int ALU_TIMEOUT     = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              sw,
  input  logic [2:0]              btn,
  calc_sequencer_if.master        alu,
  output logic [7:0]              led,
  output logic [2:0]              state_code,
  output logic                    busy
);
  localparam int TMO_W = $clog2(ALU_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  logic [7:0]            sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [2:0]            btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [2:0]            deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]            pls;
  logic                  ent_p, op_p, clr_p;

  state_t                state_q, state_d;
  logic [7:0]            a_q, a_d, b_q, b_d, res_q, res_d, led_q, led_d;
  logic [1:0]            op_q, op_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  start_q, start_d, busy_q, busy_d;

  always_comb begin
    sw_s1_d    = sw;
    sw_s2_d    = sw_s1_q;
    btn_s1_d   = btn;
    btn_s2_d   = btn_s1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    cnt_d      = '0;
    // The counter only runs while the synchronised level disagrees with the accepted one.
    for (int i = 0; i < 3; i++) begin
      if (btn_s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign pls   = deb_q & ~deb_prev_q;
  assign ent_p = pls[0];
  assign op_p  = pls[1];
  assign clr_p = pls[2];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    tmo_d   = tmo_q;
    start_d = 1'b0;
    if (clr_p) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      res_d   = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        S_A: if (ent_p) begin
          a_d     = sw_s2_q;
          state_d = S_B;
        end
        S_B: if (ent_p) begin
          b_d     = sw_s2_q;
          state_d = S_OP;
        end
        S_OP: begin
          if (ent_p) begin
            state_d = S_EXEC;
            start_d = 1'b1;
            tmo_d   = '0;
          end else if (op_p) begin
            op_d = op_q + 1'b1;
          end
        end
        S_EXEC: begin
          if (alu.alu_done) begin
            if (alu.alu_err) begin
              state_d = S_ERR;
            end else begin
              res_d   = alu.alu_result;
              state_d = S_SHOW;
            end
          end else if (tmo_q == TMO_W'(ALU_TIMEOUT - 1)) begin
            state_d = S_ERR;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (ent_p) begin
            state_d = S_A;
          end else if (op_p) begin
            a_d     = res_q;
            state_d = S_B;
          end
        end
        S_ERR: if (ent_p) state_d = S_A;
        default: state_d = S_A;
      endcase
    end
  end

  // Display follows the state being entered so led changes together with state_code.
  always_comb begin
    led_d  = '0;
    busy_d = (state_d == S_EXEC);
    case (state_d)
      S_A, S_B: led_d = sw_s2_q;
      S_OP:     led_d = {6'b0, op_d};
      S_EXEC:   led_d = led_q;
      S_SHOW:   led_d = res_d;
      S_ERR:    led_d = 8'hFF;
      default:  led_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
      state_q    <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_q      <= '0;
      tmo_q      <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      led_q      <= '0;
    end else begin
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_q      <= res_d;
      tmo_q      <= tmo_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      led_q      <= led_d;
    end
  end

  assign alu.alu_a     = a_q;
  assign alu.alu_b     = b_q;
  assign alu.alu_op    = op_q;
  assign alu.alu_start = start_q;
  assign led           = led_q;
  assign state_code    = state_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: ALU stub answering 3 cycles after start, press-level reference model.
// Checks state, operands, display and start-pulse count after each button press.
module tb_calc_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic [2:0] btn;
  logic [7:0] led;
  logic [2:0] state_code;
  logic       busy;

  calc_sequencer_if alu_if();

  calc_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(20),
    .ALU_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .btn(btn),
    .alu(alu_if),
    .led(led),
    .state_code(state_code),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: abstract calculator state after each complete press/release
  int         m_state;
  logic [7:0] m_a, m_b, m_res, m_led;
  logic [1:0] m_op;

  // ALU stub
  int unsigned n_start = 0;
  int unsigned alu_cd  = 0;
  bit          alu_mute = 1'b0;
  logic [7:0]  la, lb;
  logic [1:0]  lop;

  function automatic logic [8:0] calc(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      2'd0:    return {1'b0, 8'(a + b)};
      2'd1:    return {1'b0, 8'(a - b)};
      2'd2:    return {1'b0, p[7:0]};
      default: return (b == 8'd0) ? 9'h100 : {1'b0, 8'(a / b)};
    endcase
  endfunction

  initial begin
    logic [8:0] r;
    alu_if.alu_done   = 1'b0;
    alu_if.alu_err    = 1'b0;
    alu_if.alu_result = 8'h00;
    forever begin
      @(negedge clk);
      alu_if.alu_done = 1'b0;
      alu_if.alu_err  = 1'b0;
      if (alu_if.alu_start === 1'b1) begin
        n_start++;
        la = alu_if.alu_a;
        lb = alu_if.alu_b;
        lop = alu_if.alu_op;
        alu_cd = 3;
      end else if (alu_cd > 0) begin
        alu_cd--;
        if (alu_cd == 0 && !alu_mute) begin
          r = calc(la, lb, lop);
          alu_if.alu_done   = 1'b1;
          alu_if.alu_err    = r[8];
          alu_if.alu_result = r[7:0];
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_state = 0;
    m_a = 8'h00; m_b = 8'h00; m_op = 2'd0; m_res = 8'h00;
  endtask

  task automatic model_led();
    case (m_state)
      0, 1:    m_led = sw;
      2:       m_led = {6'b0, m_op};
      4:       m_led = m_res;
      5:       m_led = 8'hFF;
      default: m_led = m_led;
    endcase
  endtask

  task automatic model_step(input logic [2:0] mask);
    logic [8:0] r;
    if (mask[2]) begin
      model_clear();
    end else if (mask[0]) begin
      case (m_state)
        0: begin m_a = sw; m_state = 1; end
        1: begin m_b = sw; m_state = 2; end
        2: begin
          if (alu_mute) begin
            m_state = 3;
          end else begin
            r = calc(m_a, m_b, m_op);
            if (r[8]) m_state = 5;
            else begin m_res = r[7:0]; m_state = 4; end
          end
        end
        4, 5: m_state = 0;
        default: m_state = m_state;
      endcase
    end else if (mask[1]) begin
      if (m_state == 2) m_op = m_op + 2'd1;
      else if (m_state == 4) begin m_a = m_res; m_state = 1; end
    end
    model_led();
  endtask

  task automatic press(input logic [2:0] mask);
    @(negedge clk);
    btn = mask;
    repeat (12) @(negedge clk);
    btn = 3'b000;
    repeat (12) @(negedge clk);
    model_step(mask);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(state_code), 32'(m_state));
    chk({tag, ".a"},     32'(alu_if.alu_a), 32'(m_a));
    chk({tag, ".b"},     32'(alu_if.alu_b), 32'(m_b));
    chk({tag, ".op"},    32'(alu_if.alu_op), 32'(m_op));
    chk({tag, ".led"},   32'(led), 32'(m_led));
    chk({tag, ".busy"},  32'(busy), 32'(m_state == 3));
  endtask

  initial begin
    int unsigned s0;
    bit found;
    rst = 1'b1;
    sw  = 8'h00;
    btn = 3'b000;
    model_clear();
    m_led = 8'h00;
    repeat (3) @(negedge clk);
    check_all("reset");
    chk("reset.start", 32'(alu_if.alu_start), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // directed add 11 + 22
    sw = 8'h11; press(3'b001); check_all("a_in");
    sw = 8'h22; press(3'b001); check_all("b_in");
    s0 = n_start;
    press(3'b001); check_all("add");
    chk("add.led", 32'(led), 32'h33);
    chk("add.starts", n_start - s0, 32'd1);

    // chained calc from SHOW
    press(3'b010); check_all("chain");
    chk("chain.a", 32'(alu_if.alu_a), 32'h33);
    sw = 8'h05; press(3'b001); check_all("chain_b");
    for (int i = 0; i < 5; i++) press(3'b010);
    check_all("opwrap");
    chk("opwrap.led", 32'(led), 32'h01);
    press(3'b001); check_all("sub");

    // clear together with enter
    press(3'b101); check_all("clr_ent");

    // bouncing op_sel in S_OP
    sw = 8'h40; press(3'b001);
    sw = 8'h03; press(3'b001);
    @(negedge clk); btn = 3'b010;
    repeat (2) @(negedge clk); btn = 3'b000;
    repeat (2) @(negedge clk); btn = 3'b010;
    repeat (20) @(negedge clk); btn = 3'b000;
    repeat (12) @(negedge clk);
    model_step(3'b010);
    check_all("bounce");

    // divide by zero
    press(3'b101);
    sw = 8'h9C; press(3'b001);
    sw = 8'h00; press(3'b001);
    for (int i = 0; i < 3; i++) press(3'b010);
    press(3'b001); check_all("div0");
    press(3'b001); check_all("err_exit");

    // ALU never answers
    sw = 8'h07; press(3'b001);
    press(3'b001);
    alu_mute = 1'b1;
    press(3'b001); check_all("exec_wait");
    repeat (60) @(negedge clk);
    m_state = 5; m_led = 8'hFF;
    check_all("timeout");
    alu_mute = 1'b0;
    press(3'b001); check_all("tmo_exit");

    // reset in the middle of S_EXEC; the pending done arrives after reset
    sw = 8'h21; press(3'b001);
    sw = 8'h02; press(3'b001);
    @(negedge clk); btn = 3'b001;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (alu_if.alu_start === 1'b1) found = 1'b1;
    end
    chk("rst_exec.start_seen", 32'(found), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_exec.state", 32'(state_code), 32'd0);
    chk("rst_exec.led", 32'(led), 32'd0);
    chk("rst_exec.start", 32'(alu_if.alu_start), 32'd0);
    btn = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (10) @(negedge clk);
    model_led();
    check_all("late_done");

    // randomized rounds
    for (int k = 0; k < 8; k++) begin
      sw = 8'($urandom); press(3'b001);
      sw = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom); press(3'b001);
      for (int j = $urandom_range(0, 4); j > 0; j--) press(3'b010);
      check_all("rnd_op");
      press($urandom_range(0, 1) ? 3'b011 : 3'b001);
      check_all("rnd_exec");
      if (m_state == 4 && $urandom_range(0, 1) == 1) begin
        press(3'b010);
        sw = 8'($urandom); press(3'b001);
        press(3'b001);
        check_all("rnd_chain");
      end
      press(3'b001);
      check_all("rnd_exit");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
